// File: rtl/modulo_folder_if.sv
// Sample/result bundle for the modulo folder: the producer drives en/x,
// the folder returns residue, fold counts and status flags.
interface modulo_folder_if #(
  parameter int IN_RES  = 20,
  parameter int OUT_RES = 16,
  parameter int K_RES   = 8
);
  logic                      en;
  logic signed [IN_RES-1:0]  x;
  logic signed [OUT_RES-1:0] residue;
  logic signed [K_RES-1:0]   fold;
  logic signed [K_RES-1:0]   kn;
  logic                      valid;
  logic                      busy;
  logic                      ovf;
  logic                      miss;

  modport master (
    output en, x,
    input  residue, fold, kn, valid, busy, ovf, miss
  );

  modport slave (
    input  en, x,
    output residue, fold, kn, valid, busy, ovf, miss
  );
endinterface

// File: rtl/modulo_folder.sv
// Self-reflexive modulo encoder: folds a wide signed sample into
// [-LAMBDA, LAMBDA) one 2*LAMBDA step per cycle, reporting fold count and Kn.
module modulo_folder #(
  parameter int IN_RES    = 20,
  parameter int OUT_RES   = 16,
  parameter int LAMBDA    = 4096,
  parameter int K_RES     = 8,
  parameter int MAX_FOLDS = 15
) (
  input  logic            clk,
  input  logic            reset,
  modulo_folder_if.slave  bus
);

  localparam int ACC_W = IN_RES + 2;

  localparam logic signed [ACC_W-1:0]   LAM_POS = ACC_W'(LAMBDA);
  localparam logic signed [ACC_W-1:0]   LAM_NEG = ACC_W'(-LAMBDA);
  localparam logic signed [ACC_W-1:0]   STEP    = ACC_W'(2 * LAMBDA);
  localparam logic signed [K_RES-1:0]   K_MAX   = K_RES'(MAX_FOLDS);
  localparam logic signed [K_RES-1:0]   K_ONE   = K_RES'(1);
  localparam logic signed [OUT_RES-1:0] RES_HI  = OUT_RES'(LAMBDA - 1);
  localparam logic signed [OUT_RES-1:0] RES_LO  = OUT_RES'(-LAMBDA);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FOLD = 1'b1
  } state_t;

  state_t                    state_r, state_s;
  logic signed [ACC_W-1:0]   acc_r, acc_s;
  logic signed [K_RES-1:0]   k_r, k_s;
  logic signed [K_RES-1:0]   k_prev_r, k_prev_s;
  logic signed [K_RES-1:0]   k_abs_s;
  logic                      at_max_s;
  logic signed [OUT_RES-1:0] residue_r, residue_s;
  logic signed [K_RES-1:0]   fold_r, fold_s;
  logic signed [K_RES-1:0]   kn_r, kn_s;
  logic                      valid_r, valid_s;
  logic                      busy_r, busy_s;
  logic                      ovf_r, ovf_s;
  logic                      miss_r, miss_s;

  // Next-state, fold step and finalisation logic
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    k_s       = k_r;
    k_prev_s  = k_prev_r;
    residue_s = residue_r;
    fold_s    = fold_r;
    kn_s      = kn_r;
    valid_s   = 1'b0;
    ovf_s     = ovf_r;
    miss_s    = miss_r;
    k_abs_s   = k_r[K_RES-1] ? -k_r : k_r;
    at_max_s  = (k_abs_s >= K_MAX);

    case (state_r)
      IDLE: begin
        if (bus.en) begin
          acc_s   = {{2{bus.x[IN_RES-1]}}, bus.x};
          k_s     = '0;
          state_s = FOLD;
        end else begin
          state_s = IDLE;
        end
      end
      FOLD: begin
        // A new sample arriving mid-fold is dropped, never merged
        miss_s = miss_r | bus.en;
        if ((acc_r >= LAM_POS) && !at_max_s) begin
          acc_s = acc_r - STEP;
          k_s   = k_r + K_ONE;
        end else if ((acc_r < LAM_NEG) && !at_max_s) begin
          acc_s = acc_r + STEP;
          k_s   = k_r - K_ONE;
        end else begin
          state_s  = IDLE;
          valid_s  = 1'b1;
          fold_s   = k_r;
          kn_s     = k_r - k_prev_r;
          k_prev_s = k_r;
          if (acc_r >= LAM_POS) begin
            residue_s = RES_HI;
            ovf_s     = 1'b1;
          end else if (acc_r < LAM_NEG) begin
            residue_s = RES_LO;
            ovf_s     = 1'b1;
          end else begin
            residue_s = acc_r[OUT_RES-1:0];
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s == FOLD);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      acc_r     <= '0;
      k_r       <= '0;
      k_prev_r  <= '0;
      residue_r <= '0;
      fold_r    <= '0;
      kn_r      <= '0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      ovf_r     <= 1'b0;
      miss_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      acc_r     <= acc_s;
      k_r       <= k_s;
      k_prev_r  <= k_prev_s;
      residue_r <= residue_s;
      fold_r    <= fold_s;
      kn_r      <= kn_s;
      valid_r   <= valid_s;
      busy_r    <= busy_s;
      ovf_r     <= ovf_s;
      miss_r    <= miss_s;
    end
  end

  assign bus.residue = residue_r;
  assign bus.fold    = fold_r;
  assign bus.kn      = kn_r;
  assign bus.valid   = valid_r;
  assign bus.busy    = busy_r;
  assign bus.ovf     = ovf_r;
  assign bus.miss    = miss_r;

endmodule

// File: tb/tb_modulo_folder.sv
// Scoreboard bench for modulo_folder: arithmetic reference model, directed
// plan sequences followed by randomized samples, drops and resets.
module tb_modulo_folder;

  localparam int IN_RES    = 20;
  localparam int OUT_RES   = 16;
  localparam int LAMBDA    = 4096;
  localparam int K_RES     = 8;
  localparam int MAX_FOLDS = 15;

  typedef struct {
    int res;
    int fold;
    int kn;
    int cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;

  exp_t sb[$];
  int   kprev;
  int   free_cyc;
  int   busy_lo;
  int   busy_hi;
  int   ovf_from;
  int   miss_from;
  int   held_res;
  int   held_fold;
  int   held_kn;

  modulo_folder_if #(.IN_RES(IN_RES), .OUT_RES(OUT_RES), .K_RES(K_RES)) bus_if ();

  modulo_folder #(
    .IN_RES(IN_RES), .OUT_RES(OUT_RES), .LAMBDA(LAMBDA),
    .K_RES(K_RES), .MAX_FOLDS(MAX_FOLDS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests = n_tests + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: x = residue + 2*LAMBDA*k with residue in [-LAMBDA, LAMBDA), |k| clamped
  function automatic void ref_fold(input int v, output int res, output int k, output bit ov);
    int kk;
    kk = floor_div(v + LAMBDA, 2 * LAMBDA);
    if (kk > MAX_FOLDS) begin
      k = MAX_FOLDS; res = LAMBDA - 1; ov = 1'b1;
    end else if (kk < -MAX_FOLDS) begin
      k = -MAX_FOLDS; res = -LAMBDA; ov = 1'b1;
    end else begin
      k = kk; res = v - 2 * LAMBDA * kk; ov = 1'b0;
    end
  endfunction

  task automatic model_clear();
    kprev     = 0;
    free_cyc  = cyc;
    busy_lo   = 1;
    busy_hi   = 0;
    ovf_from  = -1;
    miss_from = -1;
  endtask

  task automatic idle1();
    @(posedge clk); #1;
    bus_if.en = 1'b0;
  endtask

  task automatic send(input int v);
    int   r, k, c, m;
    bit   o;
    exp_t e;
    @(posedge clk); #1;
    bus_if.en = 1'b1;
    bus_if.x  = 20'(v);
    c = cyc;
    if (c >= free_cyc) begin
      ref_fold(v, r, k, o);
      m = (k < 0) ? -k : k;
      e.res  = r;
      e.fold = k;
      e.kn   = k - kprev;
      e.cyc  = c + 2 + m;
      sb.push_back(e);
      kprev    = k;
      busy_lo  = c + 1;
      busy_hi  = c + 1 + m;
      free_cyc = c + 2 + m;
      if (o && ovf_from < 0) ovf_from = c + 2 + m;
    end else if (miss_from < 0) begin
      miss_from = c + 1;
    end
  endtask

  // Idle until the cycle before the folder returns to IDLE, so the next send lands on it
  task automatic wait_free();
    for (int i = 0; i < 64; i++) begin
      if (cyc >= free_cyc - 1) break;
      idle1();
    end
  endtask

  task automatic do_reset(input bit with_en);
    @(posedge clk); #1;
    reset     = 1'b1;
    bus_if.en = with_en;
    bus_if.x  = 20'(1000);
    sb.delete();
    @(posedge clk); #1;
    reset     = 1'b0;
    bus_if.en = 1'b0;
    model_clear();
    chk("rst_residue", int'($signed(bus_if.residue)), 0);
    chk("rst_fold",    int'($signed(bus_if.fold)), 0);
    chk("rst_kn",      int'($signed(bus_if.kn)), 0);
    chk("rst_valid",   int'(bus_if.valid), 0);
    chk("rst_busy",    int'(bus_if.busy), 0);
    chk("rst_ovf",     int'(bus_if.ovf), 0);
    chk("rst_miss",    int'(bus_if.miss), 0);
  endtask

  // Monitor: sticky flags and busy every cycle, results popped on valid
  initial begin
    exp_t e;
    held_res = 0; held_fold = 0; held_kn = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_res = 0; held_fold = 0; held_kn = 0;
      end else begin
        chk("busy", int'(bus_if.busy), int'(cyc >= busy_lo && cyc <= busy_hi));
        chk("ovf",  int'(bus_if.ovf),  int'(ovf_from >= 0 && cyc >= ovf_from));
        chk("miss", int'(bus_if.miss), int'(miss_from >= 0 && cyc >= miss_from));
        if (bus_if.valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_valid", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("valid_cycle", cyc, e.cyc);
            chk("residue", int'($signed(bus_if.residue)), e.res);
            chk("fold",    int'($signed(bus_if.fold)), e.fold);
            chk("kn",      int'($signed(bus_if.kn)), e.kn);
            held_res = e.res; held_fold = e.fold; held_kn = e.kn;
          end
        end else begin
          if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("missing_valid", 0, 1);
          end
          chk("hold_residue", int'($signed(bus_if.residue)), held_res);
          chk("hold_fold",    int'($signed(bus_if.fold)), held_fold);
          chk("hold_kn",      int'($signed(bus_if.kn)), held_kn);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int sel;
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus_if.en = 1'b0;
    bus_if.x  = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    chk("init_residue", int'($signed(bus_if.residue)), 0);
    chk("init_valid",   int'(bus_if.valid), 0);
    chk("init_busy",    int'(bus_if.busy), 0);

    // Directed plan sequences
    send(1000);    wait_free();
    send(10000);   wait_free();
    send(-20000);  wait_free();
    send(4096);    wait_free();
    send(-4096);   wait_free();
    send(200000);  wait_free();
    send(0);       wait_free();
    idle1();
    send(10000);
    send(5);
    idle1();
    send(5);       wait_free();
    send(200000);
    repeat (4) idle1();
    do_reset(1'b0);
    send(1000);    wait_free();
    do_reset(1'b1);
    idle1();
    chk("reset_blocks_en_busy", int'(bus_if.busy), 0);

    // Randomized traffic with occasional drops and resets
    for (int i = 0; i < 200; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 3) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        if (sel < 85) begin
          wait_free();
          repeat ($urandom_range(0, 2)) idle1();
        end
        if ($urandom_range(0, 3) == 0)
          v = int'($urandom_range(0, 1048575)) - 524288;
        else
          v = int'($urandom_range(0, 260000)) - 130000;
        send(v);
      end
    end

    wait_free();
    repeat (3) idle1();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      idle1();
    end
    chk("drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
